mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single-port 8-bit program/data memory between the simproc core (port 0) and the debug/loader host (port 1).
- Serialises accesses through a small FSM, one access at a time, using a req/gnt handshake per port.
- Returns read data with a registered rvalid pulse.
- Sits between simproc's mem_* interface and the memory macro.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- RD_LATENCY, 1, memory read latency in cycles (legal 1..3): cycles from the issue-edge to mem_dout valid.

Ports:
- clk  in  1  clock, single domain.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  port 0 (core) access request; held with fields stable until m0_gnt.
- m0_we  in  1  port 0 write enable (1 = write, 0 = read).
- m0_addr  in  ADDR_W  port 0 address.
- m0_wdata  in  DATA_W  port 0 write data.
- m0_gnt  out  1  port 0 grant, 1-cycle pulse.
- m0_rvalid  out  1  port 0 read data valid, 1-cycle pulse.
- m0_rdata  out  DATA_W  port 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for the debug host.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_we  out  1  memory write strobe.
- mem_dout  in  DATA_W  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (sync, active-high; clk/rst as named above):
  - state = IDLE; all gnt, rvalid, mem_we and busy = 0.
  - mem_addr, mem_din, m0_rdata, m1_rdata = 0; wait counter = 0.
  - RR pointer set so port 0 wins the first tie.
- FSM states IDLE, ISSUE, WAIT.
- IDLE:
  - If no req, stay in IDLE.
  - Otherwise choose a winner and register its we/addr/wdata into mem_we/mem_addr/mem_din and its gnt.
  - Next state ISSUE.
- ISSUE (exactly 1 cycle):
  - The winner's gnt = 1; mem_* carry the command. The memory captures it at the closing edge.
  - If write: next state IDLE. No rvalid is produced.
  - If read: load the wait counter with RD_LATENCY; next state WAIT.
- WAIT:
  - Decrement the counter each cycle. mem_we = 0.
  - In the final WAIT cycle (counter == 1), register mem_dout into the winner's rdata and set the winner's rvalid.
  - Next state IDLE.
- mem_we is 1 only in ISSUE of a write. mem_addr and mem_din hold their last issued value otherwise.
- rvalid is a 1-cycle pulse in the cycle after the last WAIT cycle, overlapping IDLE. rdata holds until the next read on that port.
- Latency, with req first high in cycle 0:
  - gnt in cycle 1.
  - Write: next grant possible in cycle 3.
  - Read: rvalid in cycle 2+RD_LATENCY; next gnt at the earliest in cycle 3+RD_LATENCY.
- Arbitration (default round-robin):
  - If only one req is high, that port wins.
  - If both are high, the port not granted last wins.
  - The RR pointer updates on each grant.
  - No starvation: with both requesting continuously, grants alternate.
- Handshake:
  - A requester holds req/we/addr/wdata until it samples gnt = 1. It may drop or change req in the following cycle.
  - Req is sampled only in IDLE. A req asserted during ISSUE or WAIT waits.
  - Dropping req before gnt is illegal; the resulting behaviour is undefined.
- Never more than one outstanding access. gnt for both ports is never high in the same cycle, and neither is rvalid.
- Reset mid-operation: the FSM aborts to IDLE next cycle and any pending rvalid is suppressed. A write already in ISSUE at the reset edge has been presented to memory and is not retracted.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 1 (debug) always wins a tie and the RR pointer is not implemented. Port 0 may starve while m1_req stays high.
- Undefined: round-robin as above.

Test Plan:
- Reset then idle, no req for 10 cycles -> all outputs 0, busy = 0, mem_we never 1.
- Port 0 write addr 0x10 data 0xA5 at cycle 0 -> m0_gnt and mem_we = 1, mem_addr = 0x10, mem_din = 0xA5 in cycle 1. Then port 0 read 0x10 -> m0_rvalid = 1, m0_rdata = 0xA5 at 2+RD_LATENCY cycles after req; m1_rvalid stays 0.
- Both ports request reads continuously (default build) -> grants alternate 0,1,0,1. First grant goes to port 0 after reset. Each rvalid appears on the matching port only.
- Same stimulus with MEM_ARB_FIXED_PRIO_EN -> every grant goes to port 1 while m1_req = 1; port 0 is granted only after m1_req drops.
- Port 1 read issued, rst asserted during WAIT -> next cycle state IDLE, busy = 0, m1_rvalid never pulses. The next m0 request after reset is granted normally.
- RD_LATENCY = 3 build, port 0 read of a location preloaded with 0x3C -> busy high 4 cycles (ISSUE + 3 WAIT), m0_rvalid in cycle 5 with 0x3C.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter for the shared single-port program/data memory.
// Port 0 is the simproc core and port 1 is the debug/loader host. Accesses are
// serialised one at a time with a req/gnt handshake per port. Reads return data
// with a registered one-cycle rvalid pulse.
// Build option: define MEM_ARB_FIXED_PRIO_EN so that port 1 wins every tie and
// no round-robin pointer exists. Leave it undefined for round-robin arbitration.
module mem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_winner;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memDin;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [CNT_W-1:0]  r_waitCnt;
    logic              w_anyReq;
    logic              w_winner;

    assign w_anyReq = m0_req | m1_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_winner = m1_req;
`else
    logic r_lastGnt;

    // Pick the winner: a lone requester wins; on a tie, the port not granted last wins.
    always_comb begin
        w_winner = m1_req;
        if (m0_req && m1_req) begin
            w_winner = ~r_lastGnt;
        end
    end

    // Track the port granted most recently; reset value lets port 0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastGnt <= 1'b1;
        end else if (r_state == IDLE && w_anyReq) begin
            r_lastGnt <= w_winner;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: IDLE -> ISSUE on any request; a write returns straight to IDLE, a read waits.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyReq) w_nextState = ISSUE;
            ISSUE:   w_nextState = r_memWe ? IDLE : WAIT;
            WAIT:    if (r_waitCnt == CNT_ONE) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Command, grant, wait-counter and read-return registers; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_winner  <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_memWe   <= 1'b0;
            r_memAddr <= '0;
            r_memDin  <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_waitCnt <= '0;
        end else begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_memWe   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_winner  <= w_winner;
                        r_gnt0    <= ~w_winner;
                        r_gnt1    <= w_winner;
                        r_memWe   <= w_winner ? m1_we    : m0_we;
                        r_memAddr <= w_winner ? m1_addr  : m0_addr;
                        r_memDin  <= w_winner ? m1_wdata : m0_wdata;
                    end
                end
                ISSUE: begin
                    if (!r_memWe) begin
                        r_waitCnt <= CNT_LOAD;
                    end
                end
                WAIT: begin
                    r_waitCnt <= r_waitCnt - CNT_ONE;
                    if (r_waitCnt == CNT_ONE) begin
                        if (r_winner) begin
                            r_rdata1  <= mem_dout;
                            r_rvalid1 <= 1'b1;
                        end else begin
                            r_rdata0  <= mem_dout;
                            r_rvalid0 <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_waitCnt <= '0;
                end
            endcase
        end
    end

    assign m0_gnt    = r_gnt0;
    assign m1_gnt    = r_gnt1;
    assign m0_rvalid = r_rvalid0;
    assign m1_rvalid = r_rvalid1;
    assign m0_rdata  = r_rdata0;
    assign m1_rdata  = r_rdata1;
    assign mem_addr  = r_memAddr;
    assign mem_din   = r_memDin;
    assign mem_we    = r_memWe;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized bench for mem_arbiter.
// A transaction-level model predicts grants, memory commands, busy and read
// returns from the latency and arbitration rules. A compare process checks
// every cycle against that model, and directed steps pin literal values.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int RDL = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [7:0] m0_rdata, m1_rdata;
    logic [7:0] mem_addr, mem_din, mem_dout;
    logic       mem_we, busy;

    int testsRun    = 0;
    int testsFailed = 0;

    mem_arbiter #(
        .ADDR_W(8),
        .DATA_W(8),
        .RD_LATENCY(RDL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m0_req(m0_req),
        .m0_we(m0_we),
        .m0_addr(m0_addr),
        .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req),
        .m1_we(m1_we),
        .m1_addr(m1_addr),
        .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .mem_addr(mem_addr),
        .mem_din(mem_din),
        .mem_we(mem_we),
        .mem_dout(mem_dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] preload(input int a);
        return 8'((a * 7 + 3) & 255);
    endfunction

    function automatic logic [3:0] slot(input int c);
        return 4'(c);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Memory macro stand-in: write on mem_we, read data appears RDL edges after the issue edge.
    logic [7:0] envMem [256];
    logic [7:0] memPipe [3];
    logic       envInit = 1'b0;
    always @(posedge clk) begin
        if (!envInit) begin
            for (int i = 0; i < 256; i++) envMem[8'(i)] <= preload(i);
            for (int i = 0; i < 3; i++) memPipe[2'(i)] <= 8'h00;
            envInit <= 1'b1;
        end else begin
            memPipe[0] <= envMem[mem_addr];
            memPipe[1] <= memPipe[0];
            memPipe[2] <= memPipe[1];
            if (mem_we) envMem[mem_addr] <= mem_din;
        end
    end
    assign mem_dout = memPipe[RDL-1];

    // Transaction-level model: expected events per future cycle in a 16-slot ring.
    int         cyc       = 0;
    bit         modelLive = 1'b0;
    int         nextIdle  = 0;
    int         lastGrant = 1;
    logic [7:0] refMem [256];
    logic [1:0] eGnt [16];
    logic       eWe  [16];
    logic       eBusy[16];
    logic [1:0] eRv  [16];
    logic [7:0] eRd  [16];
    logic       eAs  [16];
    logic [7:0] eAd  [16];
    logic [7:0] eDi  [16];
    logic       eRst [16];

    task automatic clearSlot(input logic [3:0] s);
        eGnt[s] = 2'b00; eWe[s] = 1'b0; eBusy[s] = 1'b0; eRv[s] = 2'b00;
        eRd[s] = 8'h00; eAs[s] = 1'b0; eAd[s] = 8'h00; eDi[s] = 8'h00; eRst[s] = 1'b0;
    endtask

    initial begin
        int         c;
        int         span;
        logic       win;
        logic       wrOp;
        logic [7:0] a, d;
        forever begin
            @(posedge clk);
            c = cyc;
            if (!modelLive) begin
                for (int i = 0; i < 256; i++) refMem[8'(i)] = preload(i);
                for (int s = 0; s < 16; s++) clearSlot(4'(s));
            end
            clearSlot(slot(c + 8));
            if (rst) begin
                for (int k = 1; k <= 8; k++) clearSlot(slot(c + k));
                eRst[slot(c + 1)] = 1'b1;
                nextIdle  = c + 1;
                lastGrant = 1;
                modelLive = 1'b1;
            end else if (modelLive && c >= nextIdle && (m0_req || m1_req)) begin
                if (m0_req && m1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                    win = 1'b1;
`else
                    win = (lastGrant == 0);
`endif
                end else begin
                    win = m1_req;
                end
                lastGrant = win ? 1 : 0;
                wrOp = win ? m1_we    : m0_we;
                a    = win ? m1_addr  : m0_addr;
                d    = win ? m1_wdata : m0_wdata;
                eGnt[slot(c + 1)][win] = 1'b1;
                eWe[slot(c + 1)]       = wrOp;
                eAs[slot(c + 1)]       = 1'b1;
                eAd[slot(c + 1)]       = a;
                eDi[slot(c + 1)]       = d;
                span = wrOp ? 1 : 1 + RDL;
                for (int k = 1; k <= span; k++) eBusy[slot(c + k)] = 1'b1;
                if (wrOp) begin
                    refMem[a] = d;
                    nextIdle  = c + 2;
                end else begin
                    eRv[slot(c + 2 + RDL)][win] = 1'b1;
                    eRd[slot(c + 2 + RDL)]      = refMem[a];
                    nextIdle = c + 2 + RDL;
                end
            end
            cyc = c + 1;
        end
    end

    // Compare process: every cycle after the first reset, all outputs against the model.
    logic [7:0] hAddr = 8'h00, hDin = 8'h00, hRd0 = 8'h00, hRd1 = 8'h00;
    initial begin
        logic [3:0] s;
        forever begin
            @(negedge clk);
            if (modelLive) begin
                s = slot(cyc);
                if (eRst[s]) begin
                    hAddr = 8'h00; hDin = 8'h00; hRd0 = 8'h00; hRd1 = 8'h00;
                end
                if (eAs[s]) begin
                    hAddr = eAd[s];
                    hDin  = eDi[s];
                end
                if (eRv[s][0]) hRd0 = eRd[s];
                if (eRv[s][1]) hRd1 = eRd[s];
                checkOutput("gnt",      32'({m1_gnt, m0_gnt}),       32'(eGnt[s]));
                checkOutput("rvalid",   32'({m1_rvalid, m0_rvalid}), 32'(eRv[s]));
                checkOutput("mem_we",   32'(mem_we),                 32'(eWe[s]));
                checkOutput("busy",     32'(busy),                   32'(eBusy[s]));
                checkOutput("mem_addr", 32'(mem_addr),               32'(hAddr));
                checkOutput("mem_din",  32'(mem_din),                32'(hDin));
                checkOutput("m0_rdata", 32'(m0_rdata),               32'(hRd0));
                checkOutput("m1_rdata", 32'(m1_rdata),               32'(hRd1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [7:0] addr, input logic [7:0] data);
        if (port == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = data;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = data;
        end
    endtask

    // Directed sequences followed by a randomized two-requester phase.
    initial begin
        int  gotQ[$];
        int  expSeq[$];
        bit  m1Dropped;
        bit  pend[2];
        bit  saw[2];
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) tick();
        rst = 1'b0;

        // Reset then idle for ten cycles.
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput("idle_flags", 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, busy}), 0);
            checkOutput("idle_mem",   32'({mem_addr, mem_din}), 0);
            checkOutput("idle_rdata", 32'({m0_rdata, m1_rdata}), 0);
        end

        // Port 0 writes 0xA5 to 0x10, then reads it back.
        applyStimulus(0, 1'b1, 1'b1, 8'h10, 8'hA5);
        tick();
        checkOutput("wr_gnt",   32'({m1_gnt, m0_gnt}), 32'h1);
        checkOutput("wr_memwe", 32'(mem_we), 32'h1);
        checkOutput("wr_addr",  32'(mem_addr), 32'h10);
        checkOutput("wr_din",   32'(mem_din), 32'hA5);
        tick();
        applyStimulus(0, 1'b1, 1'b0, 8'h10, 8'h00);
        tick();
        checkOutput("rd_gnt",   32'({m1_gnt, m0_gnt}), 32'h1);
        checkOutput("rd_memwe", 32'(mem_we), 32'h0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (RDL - 1) tick();
        checkOutput("rd_early", 32'(m0_rvalid), 32'h0);
        tick();
        checkOutput("rd_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h1);
        checkOutput("rd_rdata",  32'(m0_rdata), 32'hA5);

        // Port 1 read aborted by reset during WAIT; then port 0 is served normally.
        tick();
        applyStimulus(1, 1'b1, 1'b0, 8'h20, 8'h00);
        tick();
        checkOutput("rst_gnt1", 32'({m1_gnt, m0_gnt}), 32'h2);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        checkOutput("rst_busy_wait", 32'(busy), 32'h1);
        tick();
        rst = 1'b0;
        checkOutput("rst_busy_after", 32'(busy), 32'h0);
        for (int k = 0; k < RDL + 4; k++) begin
            checkOutput("rst_no_rvalid1", 32'(m1_rvalid), 32'h0);
            tick();
        end
        applyStimulus(0, 1'b1, 1'b0, 8'h20, 8'h00);
        tick();
        checkOutput("post_rst_gnt0", 32'({m1_gnt, m0_gnt}), 32'h1);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (RDL) tick();
        checkOutput("post_rst_rvalid0", 32'({m1_rvalid, m0_rvalid}), 32'h1);
        checkOutput("post_rst_rdata0",  32'(m0_rdata), 32'hE3);

        // Fresh reset, then both ports request reads continuously.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 8'h30, 8'h00);
        applyStimulus(1, 1'b1, 1'b0, 8'h40, 8'h00);
`ifdef MEM_ARB_FIXED_PRIO_EN
        expSeq = '{1, 1, 1, 1, 0};
`else
        expSeq = '{0, 1, 0, 1, 0};
`endif
        m1Dropped = 1'b0;
        for (int k = 0; k < 80 && gotQ.size() < 5; k++) begin
            tick();
            if (gotQ.size() == 4 && !m1Dropped) begin
                applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);
                m1Dropped = 1'b1;
            end
            if (m0_gnt) gotQ.push_back(0);
            else if (m1_gnt) gotQ.push_back(1);
        end
        checkOutput("tie_count", 32'(gotQ.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("tie_grant%0d", i), (i < gotQ.size()) ? 32'(gotQ[i]) : 32'hFFFF, 32'(expSeq[i]));
        end
        tick();
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (RDL + 4) tick();
        checkOutput("tie_idle", 32'(busy), 32'h0);

        // Randomized traffic with occasional resets; requesters hold until they see gnt.
        pend[0] = 1'b0; pend[1] = 1'b0;
        saw[0]  = 1'b0; saw[1]  = 1'b0;
        for (int k = 0; k < 3400; k++) begin
            if (k >= 3000 && !pend[0] && !pend[1]) break;
            tick();
            rst = (k < 3000) && ($urandom_range(0, 299) == 0);
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && saw[p]) begin
                    if (k < 3000 && $urandom_range(0, 1) == 1) begin
                        applyStimulus(p, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
                    end else begin
                        applyStimulus(p, 1'b0, 1'b0, 8'h00, 8'h00);
                        pend[p] = 1'b0;
                    end
                end else if (!pend[p] && k < 3000 && $urandom_range(0, 3) == 0) begin
                    applyStimulus(p, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
                    pend[p] = 1'b1;
                end
            end
            saw[0] = m0_gnt;
            saw[1] = m1_gnt;
        end
        rst = 1'b0;
        checkOutput("drain_done", 32'({pend[1], pend[0]}), 32'h0);
        repeat (RDL + 4) tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
